// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared constants for the diag-v2 hazard controller: bus widths, opcodes,
// FSM encodings, forwarding selects and the register-use decode.
package hazard_ctrl_mc_pkg;

   localparam int OpBusBits      = 7;
   localparam int RsltSrcBusBits = 2;
   localparam int ForwardBusBits = 2;
   localparam int RegZero        = 0;

   localparam logic [RsltSrcBusBits-1:0] RsltSrcLOAD = 2'b01;

   localparam logic [OpBusBits-1:0] OpLUI    = 7'b0110111;
   localparam logic [OpBusBits-1:0] OpAUIPC  = 7'b0010111;
   localparam logic [OpBusBits-1:0] OpJAL    = 7'b1101111;
   localparam logic [OpBusBits-1:0] OpOP     = 7'b0110011;
   localparam logic [OpBusBits-1:0] OpOP_32  = 7'b0111011;
   localparam logic [OpBusBits-1:0] OpSTORE  = 7'b0100011;
   localparam logic [OpBusBits-1:0] OpBRANCH = 7'b1100011;
   localparam logic [OpBusBits-1:0] OpLOAD   = 7'b0000011;
   localparam logic [OpBusBits-1:0] OpOP_IMM = 7'b0010011;

   localparam logic [1:0] HzRUN   = 2'b00;
   localparam logic [1:0] HzLOADW = 2'b01;
   localparam logic [1:0] HzMDUW  = 2'b10;

   localparam logic [ForwardBusBits-1:0] ForwardM    = 2'b10;
   localparam logic [ForwardBusBits-1:0] ForwardW    = 2'b01;
   localparam logic [ForwardBusBits-1:0] ForwardNone = 2'b00;

   function automatic logic uses_rs1(input logic [OpBusBits-1:0] op);
      return !(op == OpLUI || op == OpAUIPC || op == OpJAL);
   endfunction

   function automatic logic uses_rs2(input logic [OpBusBits-1:0] op);
      return (op == OpOP || op == OpOP_32 || op == OpSTORE || op == OpBRANCH);
   endfunction

endpackage

// File: rtl/hazard_ctrl_mc_fwd_select.sv
// Per-operand forwarding select for the E stage: the younger M result wins
// over W, and x0 or a non-writing stage never forwards.
module fwd_select
   import hazard_ctrl_mc_pkg::*;
#(
   parameter int REG_ADDR_BITS = 5
) (
   input  logic [REG_ADDR_BITS-1:0]  src,
   input  logic [REG_ADDR_BITS-1:0]  write_reg_m,
   input  logic [REG_ADDR_BITS-1:0]  write_reg_w,
   input  logic                      reg_write_m,
   input  logic                      reg_write_w,
   output logic [ForwardBusBits-1:0] sel
);

   logic src_live;

   assign src_live = (src != REG_ADDR_BITS'(RegZero));

   always_comb begin
      sel = ForwardNone;
      if (src_live && reg_write_m && src == write_reg_m) begin
         sel = ForwardM;
      end else if (src_live && reg_write_w && src == write_reg_w) begin
         sel = ForwardW;
      end
   end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller for the 5-stage diag-v2 core: load-use with a
// configurable penalty, MDU hold handshake, memory wait states and forwarding.
module hazard_ctrl_mc
   import hazard_ctrl_mc_pkg::*;
#(
   parameter int REG_ADDR_BITS   = 5,
   parameter int LOAD_USE_CYCLES = 1,
   parameter int CNT_BITS        = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [OpBusBits-1:0]      opD,
   input  logic [REG_ADDR_BITS-1:0]  readRegister1D,
   input  logic [REG_ADDR_BITS-1:0]  readRegister2D,
   input  logic [REG_ADDR_BITS-1:0]  readRegister1E,
   input  logic [REG_ADDR_BITS-1:0]  readRegister2E,
   input  logic [REG_ADDR_BITS-1:0]  writeRegE,
   input  logic [REG_ADDR_BITS-1:0]  writeRegM,
   input  logic [REG_ADDR_BITS-1:0]  writeRegW,
   input  logic [RsltSrcBusBits-1:0] resultSrcE,
   input  logic                      regWriteM,
   input  logic                      regWriteW,
   input  logic                      branchE,
   input  logic                      mduValidE,
   input  logic                      mduDone,
   input  logic                      memAccessM,
   input  logic                      memReadyM,
   output logic                      stallF,
   output logic                      stallD,
   output logic                      stallE,
   output logic                      stallM,
   output logic                      flushD,
   output logic                      flushE,
   output logic                      flushM,
   output logic                      flushW,
   output logic [ForwardBusBits-1:0] forwardAE,
   output logic [ForwardBusBits-1:0] forwardBE,
   output logic                      mduStart
);

   logic [1:0]          state;
   logic [1:0]          next_state;
   logic [CNT_BITS-1:0] cnt;
   logic [CNT_BITS-1:0] cnt_next;
   logic                mem_wait;
   logic                load_use;
   logic                hit_rs1;
   logic                hit_rs2;
   logic                dest_live;

   assign mem_wait  = memAccessM & ~memReadyM;
   assign dest_live = (writeRegE != REG_ADDR_BITS'(RegZero));
   assign hit_rs1   = uses_rs1(opD) && (readRegister1D == writeRegE);
   assign hit_rs2   = uses_rs2(opD) && (readRegister2D == writeRegE);
   assign load_use  = (resultSrcE == RsltSrcLOAD) && dest_live && (hit_rs1 || hit_rs2);

   fwd_select #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_fwd_a (
      .src         (readRegister1E),
      .write_reg_m (writeRegM),
      .write_reg_w (writeRegW),
      .reg_write_m (regWriteM),
      .reg_write_w (regWriteW),
      .sel         (forwardAE)
   );

   fwd_select #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_fwd_b (
      .src         (readRegister2E),
      .write_reg_m (writeRegM),
      .write_reg_w (writeRegW),
      .reg_write_m (regWriteM),
      .reg_write_w (regWriteW),
      .sel         (forwardBE)
   );

   // A memory wait freezes the FSM, but a finishing MDU must still be seen
   // or its single-cycle done pulse would be lost.
   always_comb begin
      stallF     = 1'b0;
      stallD     = 1'b0;
      stallE     = 1'b0;
      stallM     = 1'b0;
      flushD     = 1'b0;
      flushE     = 1'b0;
      flushM     = 1'b0;
      flushW     = 1'b0;
      mduStart   = 1'b0;
      next_state = state;
      cnt_next   = cnt;
      if (reset) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
         flushW = 1'b1;
      end else if (mem_wait) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
         if (state == HzMDUW && mduDone) begin
            next_state = HzRUN;
         end
      end else begin
         case (state)
            HzMDUW: begin
               if (mduDone) begin
                  next_state = HzRUN;
               end else begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  stallE = 1'b1;
                  flushM = 1'b1;
               end
            end
            HzLOADW: begin
               stallF   = 1'b1;
               stallD   = 1'b1;
               flushE   = 1'b1;
               cnt_next = cnt - CNT_BITS'(1);
               if (cnt <= CNT_BITS'(1)) begin
                  next_state = HzRUN;
               end
            end
            default: begin
               if (branchE) begin
                  flushD = 1'b1;
                  flushE = 1'b1;
               end else if (mduValidE) begin
                  mduStart   = 1'b1;
                  stallF     = 1'b1;
                  stallD     = 1'b1;
                  stallE     = 1'b1;
                  flushM     = 1'b1;
                  next_state = HzMDUW;
               end else if (load_use) begin
                  stallF = 1'b1;
                  stallD = 1'b1;
                  flushE = 1'b1;
                  if (LOAD_USE_CYCLES > 1) begin
                     next_state = HzLOADW;
                     cnt_next   = CNT_BITS'(LOAD_USE_CYCLES - 1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= HzRUN;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

endmodule
